// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
// Optional warm-up output masking is enabled with FIR_CTRL_WARMUP_MASK_EN.
package fir_ctrl_pkg;

    localparam int FIR_TAPS       = 32;
    localparam int FIR_COEFF_W    = 16;
    localparam int FIR_SAMPLE_W   = 16;
    localparam int FIR_PIPE_DEPTH = 6;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } fir_state_e;

    typedef logic signed [FIR_COEFF_W-1:0] coeff_bank_t [FIR_TAPS];

    // Accepted samples needed before the tap window and pipeline hold only fresh data.
    function automatic int warmup_len(input int taps, input int pipe_depth);
        return taps + pipe_depth + 1;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair with a software write port and a swap strobe.
// A write coinciding with a swap lands in shadow only; the swap copies the pre-write shadow.
module fir_coeff_bank #(
    parameter int TAPS    = 32,
    parameter int COEFF_W = 16,
    parameter int IDX_W   = $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_wr_en,
    input  logic [IDX_W-1:0]          i_wr_idx,
    input  logic [COEFF_W-1:0]        i_wr_data,
    input  logic                      i_swap,
    output logic [TAPS*COEFF_W-1:0]   o_active_flat
);

    logic [COEFF_W-1:0] r_shadow [TAPS];
    logic [COEFF_W-1:0] r_active [TAPS];
    logic               w_idx_ok;

    generate
        if ((2 ** IDX_W) == TAPS) begin : g_idx_full
            assign w_idx_ok = 1'b1;
        end else begin : g_idx_check
            assign w_idx_ok = (32'(i_wr_idx) < TAPS);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (i_swap) begin
                for (int i = 0; i < TAPS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (i_wr_en && w_idx_ok) begin
                r_shadow[i_wr_idx] <= i_wr_data;
            end
        end
    end

    generate
        for (genvar g = 0; g < TAPS; g++) begin : g_flat
            assign o_active_flat[g*COEFF_W +: COEFF_W] = r_active[g];
        end
    endgenerate

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Sequencer in front of the pipelined FIR: gates samples, swaps coefficient banks glitch-free,
// and qualifies filter outputs. Warm-up masking is compiled in with FIR_CTRL_WARMUP_MASK_EN.
//   state    | meaning
//   OFF      | filter disabled, commits swap immediately
//   RUN      | samples accepted and forwarded to the filter
//   CLEAR    | one-cycle filter flush while the banks swap
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS       = FIR_TAPS,
    parameter int COEFF_W    = FIR_COEFF_W,
    parameter int SAMPLE_W   = FIR_SAMPLE_W,
    parameter int PIPE_DEPTH = FIR_PIPE_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run_en,
    input  logic                      cfg_wr_en,
    input  logic [$clog2(TAPS)-1:0]   cfg_wr_idx,
    input  logic [COEFF_W-1:0]        cfg_wr_data,
    input  logic                      commit,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_W-1:0]       s_data,
    output logic                      fir_enable,
    output logic                      fir_signal_valid,
    output logic [SAMPLE_W-1:0]       fir_signal,
    output logic [TAPS*COEFF_W-1:0]   fir_coeff,
    input  logic                      fir_out_valid,
    input  logic [SAMPLE_W-1:0]       fir_out_data,
    output logic                      m_valid,
    output logic [SAMPLE_W-1:0]       m_data,
    output logic                      commit_done,
    output logic [1:0]                state
);

    fir_state_e          r_state;
    fir_state_e          w_state_nxt;
    logic                w_run;
    logic                w_swap;
    logic                w_accept;
    logic                w_qualified;
    logic                r_m_valid;
    logic [SAMPLE_W-1:0] r_m_data;
    logic                r_commit_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF: begin
                if (run_en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!run_en)     w_state_nxt = ST_OFF;
                else if (commit) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_state_nxt = run_en ? ST_RUN : ST_OFF;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    // A commit outside RUN (or while RUN is being left) swaps at once; in RUN it waits for CLEAR.
    always_comb begin
        w_run  = (r_state == ST_RUN);
        w_swap = 1'b0;
        case (r_state)
            ST_OFF:   w_swap = commit;
            ST_RUN:   w_swap = commit && !run_en;
            ST_CLEAR: w_swap = 1'b1;
            default:  w_swap = 1'b0;
        endcase
    end

    assign fir_enable       = w_run;
    assign s_ready          = w_run;
    assign w_accept         = s_valid && w_run;
    assign fir_signal_valid = w_accept;
    assign fir_signal       = s_data;
    assign state            = r_state;

    fir_coeff_bank #(
        .TAPS    (TAPS),
        .COEFF_W (COEFF_W)
    ) u_bank (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_en       (cfg_wr_en),
        .i_wr_idx      (cfg_wr_idx),
        .i_wr_data     (cfg_wr_data),
        .i_swap        (w_swap),
        .o_active_flat (fir_coeff)
    );

`ifdef FIR_CTRL_WARMUP_MASK_EN
    localparam int WARMUP = warmup_len(TAPS, PIPE_DEPTH);
    localparam int WARM_W = $clog2(WARMUP + 1);

    logic [WARM_W-1:0] r_warm_cnt;
    logic [WARM_W-1:0] w_warm_inc;

    // Count including this cycle's sample, so sample number WARMUP is the first qualified one.
    always_comb begin
        w_warm_inc = r_warm_cnt;
        if (w_accept && (r_warm_cnt < WARM_W'(WARMUP))) begin
            w_warm_inc = r_warm_cnt + 1'b1;
        end
    end

    assign w_qualified = (w_warm_inc >= WARM_W'(WARMUP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
        end else if (w_run && run_en) begin
            r_warm_cnt <= w_warm_inc;
        end else begin
            r_warm_cnt <= '0;
        end
    end
`else
    assign w_qualified = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_commit_done <= 1'b0;
        end else begin
            r_m_valid     <= fir_out_valid && w_qualified;
            r_m_data      <= w_qualified ? fir_out_data : '0;
            r_commit_done <= w_swap;
        end
    end

    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign commit_done = r_commit_done;

endmodule
